// File: rtl/shift_arbiter.sv
// Two-requester round-robin sequencer around an 8-bit barrel shifter.
// Shift amounts above 7 are split into repeated passes through a registered data loop.

module barrel_shifter (
    input  logic [7:0] in,
    input  logic [2:0] shamt,
    input  logic       dir,
    output logic [7:0] out
);

    // Logical shift with zero fill; dir=1 shifts left.
    always_comb begin
        if (dir) begin
            out = in << shamt;
        end else begin
            out = in >> shamt;
        end
    end

endmodule

module shift_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] in0,
    input  logic [3:0] shamt0,
    input  logic       dir0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] in1,
    input  logic [3:0] shamt1,
    input  logic       dir1,
    output logic       gnt1,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       out_id,
    output logic       busy
);

    localparam int unsigned W        = 8;
    localparam int unsigned SW       = 4;
    localparam int unsigned MAX_STEP = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [W-1:0]   r_data;
    logic [SW-1:0]  r_rem;
    logic           r_dir;
    logic           r_id;
    logic           r_last;

    logic           r_gnt0;
    logic           r_gnt1;
    logic [W-1:0]   r_out;
    logic           r_out_valid;
    logic           r_out_id;
    logic           r_busy;

    logic           w_win;
    logic           w_accept;
    logic           w_finish;
    logic           w_last_pass;
    logic [SW-1:0]  w_step;
    logic [W-1:0]   w_shift_out;

    // Winner: the sole requester, or on a tie the one not granted last.
    always_comb begin
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = ~r_last;
        end else if (req1) begin
            w_win = 1'b1;
        end
    end

    // Largest pass the 3-bit shifter can take is 7.
    always_comb begin
        w_step = r_rem;
        if (r_rem > SW'(MAX_STEP)) begin
            w_step = SW'(MAX_STEP);
        end
    end

    assign w_last_pass = (r_rem == w_step);

    barrel_shifter u_shifter (
        .in    (r_data),
        .shamt (w_step[2:0]),
        .dir   (r_dir),
        .out   (w_shift_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_accept     = 1'b1;
                    w_state_next = S_PASS;
                end
            end
            S_PASS: begin
                if (w_last_pass) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, then one shifter pass per PASS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_data <= w_win ? in1    : in0;
            r_rem  <= w_win ? shamt1 : shamt0;
            r_dir  <= w_win ? dir1   : dir0;
            r_id   <= w_win;
            r_last <= w_win;
        end else if (r_state == S_PASS) begin
            r_data <= w_shift_out;
            r_rem  <= r_rem - w_step;
        end
    end

    // Result is captured on the edge entering DONE so out_valid coincides with DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt0      <= w_accept & ~w_win;
            r_gnt1      <= w_accept & w_win;
            r_out_valid <= w_finish;
            if (w_finish) begin
                r_out    <= w_shift_out;
                r_out_id <= r_id;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign busy      = r_busy;

endmodule
